frog_lane_engine: RTL and testbench

Parametrised obstacle engine for the Frog game, generalising the fixed four-car logic into NUM_LANES lanes. Each lane has a per-lane step, alternating direction and horizontal wrap-around. Lanes are updated once per frame during vertical blanking by a sequential lane scanner. The block detects player/car collisions, runs a freeze/respawn state machine, and drives a registered car-pixel flag into the VGA colour mux.

---
 rtl/frog_lane_engine_pkg.sv | 33 +++
 rtl/frog_lane_step.sv | 31 +++
 rtl/frog_lane_engine.sv | 147 ++++++++++++++
 tb/tb_frog_lane_engine.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/frog_lane_engine_pkg.sv
// Shared constants, state encoding and geometry helpers for the Frog
// obstacle engine.
//   coord_t     : 11-bit coordinate, wide enough that x + width never wraps
//   state_e     : lane engine FSM state
//   box_overlap : half-open rectangle intersection test
package frog_lane_engine_pkg;

  localparam int H_DISPLAY_D = 640;
  localparam int V_DISPLAY_D = 480;
  localparam int CAR_W_D     = 32;
  localparam int CAR_H_D     = 32;
  localparam int PLAYER_W_D  = 32;
  localparam int PLAYER_H_D  = 32;
  localparam int XW          = 11;

  typedef logic [XW-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SCAN   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_FROZEN = 2'd3
  } state_e;

  // True when [ax,ax+aw) x [ay,ay+ah) intersects [bx,bx+bw) x [by,by+bh).
  function automatic logic box_overlap(
    input coord_t ax, input coord_t ay, input coord_t aw, input coord_t ah,
    input coord_t bx, input coord_t by, input coord_t bw, input coord_t bh);
    return (ax < bx + bw) && (bx < ax + aw) &&
           (ay < by + bh) && (by < ay + ah);
  endfunction

endpackage

// File: rtl/frog_lane_step.sv
// Next x position of one lane with horizontal wrap-around.
//   x    : current x (0..H_DISPLAY-1)
//   step : pixels moved this frame
//   left : 1 = move left, 0 = move right
//   nx   : new x, always 0..H_DISPLAY-1
module frog_lane_step
  import frog_lane_engine_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_D
) (
  input  coord_t x,
  input  coord_t step,
  input  logic   left,
  output coord_t nx
);

  localparam coord_t HD = coord_t'(H_DISPLAY);

  coord_t sum;
  assign sum = x + step;

  always_comb begin
    nx = sum;
    if (left) begin
      nx = (x < step) ? x + HD - step : x - step;
    end else if (sum >= HD) begin
      nx = sum - HD;
    end
  end

endmodule

// File: rtl/frog_lane_engine.sv
// Frog obstacle engine: NUM_LANES car lanes advanced once per frame by a
// sequential scanner, player collision detection with a freeze/respawn
// FSM, and a registered car-pixel flag for the colour mux.
//   CLK, RST_N         : pixel clock, async active-low reset
//   frame_tick, enable : frame strobe, game-running qualifier
//   h_count, v_count   : current raster position
//   player_x, player_y : player box top-left
//   car_px             : raster pixel inside a car (1-cycle latency)
//   busy               : lane scan in progress
//   collision, respawn : one-cycle event pulses
//   frozen             : freeze period after a hit
module frog_lane_engine
  import frog_lane_engine_pkg::*;
#(
  parameter int NUM_LANES     = 4,
  parameter int H_DISPLAY     = H_DISPLAY_D,
  parameter int V_DISPLAY     = V_DISPLAY_D,
  parameter int LANE_Y0       = 320,
  parameter int LANE_PITCH    = 32,
  parameter int CAR_W         = CAR_W_D,
  parameter int CAR_H         = CAR_H_D,
  parameter int PLAYER_W      = PLAYER_W_D,
  parameter int PLAYER_H      = PLAYER_H_D,
  parameter int STEP_BASE     = 2,
  parameter int STEP_INC      = 1,
  parameter int INIT_SPACING  = 160,
  parameter int FREEZE_FRAMES = 60
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  output logic       car_px,
  output logic       busy,
  output logic       collision,
  output logic       frozen,
  output logic       respawn
);

  localparam int IW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CW = $clog2(FREEZE_FRAMES + 1);

  state_e                         state, state_nxt;
  logic [IW-1:0]                  idx;
  logic [NUM_LANES-1:0][XW-1:0]   lane_x;
  logic                           hit;
  logic [CW-1:0]                  frz_cnt;
  logic                           respawn_q;

  // Shared lane datapath, steered by the scan index.
  coord_t cur_x, cur_y, cur_step, new_x;
  assign cur_x    = lane_x[idx];
  assign cur_y    = coord_t'(LANE_Y0)   + coord_t'(idx) * coord_t'(LANE_PITCH);
  assign cur_step = coord_t'(STEP_BASE) + coord_t'(idx) * coord_t'(STEP_INC);

  frog_lane_step #(.H_DISPLAY(H_DISPLAY)) u_step (
    .x    (cur_x),
    .step (cur_step),
    .left (idx[0]),
    .nx   (new_x)
  );

  logic last_lane, tick_ok, frz_done, lane_hit;
  assign last_lane = (idx == IW'(NUM_LANES - 1));
  assign tick_ok   = frame_tick & enable;
  assign frz_done  = frame_tick && (frz_cnt == CW'(1));
  assign lane_hit  = box_overlap(new_x, cur_y, coord_t'(CAR_W), coord_t'(CAR_H),
                                 {1'b0, player_x}, {1'b0, player_y},
                                 coord_t'(PLAYER_W), coord_t'(PLAYER_H));

  // Raster compare against every lane; off-screen pixels clip cars that
  // extend past the right edge instead of wrapping them.
  coord_t                 hc, vc;
  logic [NUM_LANES-1:0]   pix_hit;
  logic                   on_screen;
  assign hc        = {1'b0, h_count};
  assign vc        = {1'b0, v_count};
  assign on_screen = (hc < coord_t'(H_DISPLAY)) && (vc < coord_t'(V_DISPLAY));

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_pix
    localparam coord_t LY = coord_t'(LANE_Y0 + i * LANE_PITCH);
    assign pix_hit[i] = (hc >= lane_x[i]) && (hc < lane_x[i] + coord_t'(CAR_W)) &&
                        (vc >= LY) && (vc < LY + coord_t'(CAR_H));
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (tick_ok)   state_nxt = ST_SCAN;
      ST_SCAN:   if (last_lane) state_nxt = ST_CHECK;
      ST_CHECK:  state_nxt = hit ? ST_FROZEN : ST_RUN;
      ST_FROZEN: if (frz_done)  state_nxt = ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy      = (state == ST_SCAN);
    collision = (state == ST_CHECK) && hit;
    frozen    = (state == ST_FROZEN);
  end

  assign respawn = respawn_q;

  // Lane positions, hit latch, freeze counter, pixel flag
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_LANES; i++)
        lane_x[i] <= coord_t'((i * INIT_SPACING) % H_DISPLAY);
      idx       <= '0;
      hit       <= 1'b0;
      frz_cnt   <= '0;
      respawn_q <= 1'b0;
      car_px    <= 1'b0;
    end else begin
      car_px    <= on_screen & (|pix_hit);
      respawn_q <= (state == ST_FROZEN) && frz_done;
      case (state)
        ST_RUN: if (tick_ok) begin
          idx <= '0;
          hit <= 1'b0;
        end
        ST_SCAN: begin
          lane_x[idx] <= new_x;
          hit         <= hit | lane_hit;
          idx         <= last_lane ? '0 : idx + IW'(1);
        end
        ST_CHECK: if (hit) frz_cnt <= CW'(FREEZE_FRAMES);
        ST_FROZEN: if (frame_tick) frz_cnt <= frz_cnt - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frog_lane_engine.sv
module tb_frog_lane_engine;

  localparam int N   = 4;
  localparam int HD  = 640;
  localparam int VD  = 480;
  localparam int FRZ = 60;

  logic       CLK = 1'b0, RST_N = 1'b0, frame_tick = 1'b0, enable = 1'b1;
  logic [9:0] h_count = '0, v_count = '0, player_x = '0, player_y = '0;
  logic       car_px, busy, collision, frozen, respawn;

  frog_lane_engine dut (
    .CLK(CLK), .RST_N(RST_N), .frame_tick(frame_tick), .enable(enable),
    .h_count(h_count), .v_count(v_count), .player_x(player_x), .player_y(player_y),
    .car_px(car_px), .busy(busy), .collision(collision), .frozen(frozen),
    .respawn(respawn)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int nchk = 0, nfail = 0;
  int mx[N];
  int mfrz = 0;
  int px = 600, py = 0;

  // ---------------- reference model ----------------
  function automatic int m_next(input int i, input int x);
    int st;
    st = 2 + i;
    if (i % 2 == 0) return (x + st) % HD;
    return (x - st + HD) % HD;
  endfunction

  function automatic bit m_hit(input int i, input int x);
    int y;
    y = 320 + 32 * i;
    return (x < px + 32) && (px < x + 32) && (y < py + 32) && (py < y + 32);
  endfunction

  function automatic bit m_pix(input int h, input int v);
    bit r;
    r = 0;
    if (h < HD && v < VD)
      for (int i = 0; i < N; i++)
        if (mx[i] <= h && h < mx[i] + 32 && 320 + 32 * i <= v && v < 352 + 32 * i) r = 1;
    return r;
  endfunction

  task automatic model_reset;
    for (int i = 0; i < N; i++) mx[i] = (i * 160) % HD;
    mfrz = 0;
  endtask

  // ---------------- helpers ----------------
  task automatic cyc;
    @(posedge CLK); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_player(input int x, input int y);
    px = x; py = y;
    player_x = 10'(x); player_y = 10'(y);
  endtask

  task automatic check_pos(input string tag);
    for (int i = 0; i < N; i++)
      chk($sformatf("%s_x%0d", tag, i), 32'(dut.lane_x[i]), mx[i]);
  endtask

  task automatic check_px(input int h, input int v);
    h_count = 10'(h); v_count = 10'(v);
    cyc;
    chk($sformatf("car_px_h%0d_v%0d", h, v), 32'(car_px), 32'(m_pix(h, v)));
  endtask

  task automatic do_reset;
    RST_N = 1'b0; cyc; cyc;
    RST_N = 1'b1; cyc;
    model_reset();
  endtask

  // One frame tick, checked against the model in whatever game state applies.
  task automatic tick;
    int bn, cn, ck;
    bit hm, en;
    if (mfrz > 0) begin
      frame_tick = 1'b1; cyc; frame_tick = 1'b0;
      mfrz--;
      chk("respawn_pulse", 32'(respawn), 32'(mfrz == 0));
      chk("frozen_level",  32'(frozen),  32'(mfrz != 0));
      cyc;
      chk("respawn_single", 32'(respawn), 0);
    end else begin
      en = enable;
      frame_tick = 1'b1; cyc; frame_tick = 1'b0;
      bn = 0; cn = 0; ck = -1;
      for (int k = 0; k < N + 3; k++) begin
        bn += int'(busy);
        if (collision) begin cn++; ck = k; end
        cyc;
      end
      hm = 0;
      if (en) for (int i = 0; i < N; i++) begin
        mx[i] = m_next(i, mx[i]);
        if (m_hit(i, mx[i])) hm = 1;
      end
      chk("busy_cycles", bn, en ? N : 0);
      chk("collision_count", cn, 32'(hm));
      if (hm) begin
        chk("collision_cycle", ck, N);
        mfrz = FRZ;
      end
      chk("frozen_after_scan", 32'(frozen), 32'(hm));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cn;
    model_reset();
    set_player(600, 0);
    cyc;
    chk("rst_car_px", 32'(car_px), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_collision", 32'(collision), 0);
    chk("rst_frozen", 32'(frozen), 0);
    chk("rst_respawn", 32'(respawn), 0);
    check_pos("rst");
    RST_N = 1'b1; cyc;

    // 1: pixel compares at initial positions, including edges and clipping
    check_px(0, 320);   chk("px_lane0_const", 32'(car_px), 1);
    check_px(32, 320);  chk("px_gap_const", 32'(car_px), 0);
    check_px(160, 352); chk("px_lane1_const", 32'(car_px), 1);
    check_px(31, 351);
    check_px(0, 319);
    check_px(480, 447);
    check_px(480, 448);

    // 2: single frame, no collision
    tick();
    chk("t2_x0", 32'(dut.lane_x[0]), 2);
    chk("t2_x1", 32'(dut.lane_x[1]), 157);
    chk("t2_x2", 32'(dut.lane_x[2]), 324);
    chk("t2_x3", 32'(dut.lane_x[3]), 475);

    // 3: wrap-around in both directions
    do_reset();
    for (int t = 0; t < 53; t++) tick();
    chk("t3_lane1_53", 32'(dut.lane_x[1]), 1);
    tick();
    chk("t3_lane1_54", 32'(dut.lane_x[1]), 638);
    for (int t = 54; t < 320; t++) tick();
    chk("t3_lane0_320", 32'(dut.lane_x[0]), 0);
    check_pos("t3");
    check_px(630, 320);
    check_px(639, 416 + 5);

    // 4: collision, freeze (ticks counted regardless of enable), respawn
    do_reset();
    set_player(0, 320);
    tick();
    chk("t4_frozen", 32'(frozen), 1);
    for (int t = 0; t < FRZ - 1; t++) begin
      enable = (t % 3 != 0);
      tick();
    end
    check_pos("t4_held");
    enable = 1'b1;
    tick();
    chk("t4_run_again", 32'(frozen), 0);
    set_player(600, 0);
    tick();
    check_pos("t4_moved");

    // 5: reset during the second scan cycle, player placed to collide
    do_reset();
    set_player(0, 320);
    frame_tick = 1'b1; cyc; frame_tick = 1'b0;
    cyc;
    RST_N = 1'b0; #1;
    model_reset();
    chk("t5_busy", 32'(busy), 0);
    chk("t5_collision", 32'(collision), 0);
    check_pos("t5");
    cyc; RST_N = 1'b1;
    cn = 0;
    for (int k = 0; k < N + 3; k++) begin
      cn += int'(collision) + int'(busy);
      cyc;
    end
    chk("t5_quiet", cn, 0);
    set_player(600, 0);

    // 6: disabled ticks, and a tick arriving during the scan
    enable = 1'b0;
    for (int t = 0; t < 10; t++) tick();
    check_pos("t6_disabled");
    enable = 1'b1;
    frame_tick = 1'b1; cyc; frame_tick = 1'b0;
    cyc;
    frame_tick = 1'b1; cyc; frame_tick = 1'b0;
    for (int k = 0; k < N + 3; k++) cyc;
    for (int i = 0; i < N; i++) mx[i] = m_next(i, mx[i]);
    chk("t6_idle", 32'(busy), 0);
    check_pos("t6_once");

    // randomized play
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 3) == 0) set_player($urandom_range(0, 639), $urandom_range(290, 460));
      else                           set_player($urandom_range(0, 639), $urandom_range(0, 280));
      enable = ($urandom_range(0, 4) != 0);
      tick();
      check_pos($sformatf("rnd%0d", it));
      check_px($urandom_range(0, 700), $urandom_range(300, 500));
      check_px($urandom_range(0, 639), 320 + 32 * $urandom_range(0, 3) + $urandom_range(0, 31));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
